snn_event_scheduler: RTL

//  Front-end scheduler for the SNN core. Arbitrates between three event sources: the external sensor

---
 rtl/snn_pkg.sv | 21 ++
 rtl/snn_leak_timer.sv | 42 ++++
 rtl/snn_event_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN core front end.
//   event_type_t  : kind of event issued to the core controller
//   sched_state_t : event scheduler FSM states
//   NEURON_AW     : neuron address width shared with controller / priority encoder
package snn_pkg;

    typedef enum logic [1:0] {
        SENSOR = 2'd0,
        RECUR  = 2'd1,
        LEAK   = 2'd2
    } event_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    localparam int NEURON_AW = 4;

endpackage

// File: rtl/snn_leak_timer.sv
// Periodic membrane-leak tick generator with a one-deep pending flag.
//   clock, reset  : clock, synchronous active-high reset
//   leak_en       : counter runs while 1, held at 0 while 0
//   clear_i       : scheduler is issuing the pending LEAK this cycle
//   leak_pending  : a tick is waiting to be issued
//   leak_overrun  : sticky, a tick arrived while an unconsumed tick was pending
module snn_leak_timer #(
    parameter int LEAK_PERIOD = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic leak_en,
    input  logic clear_i,
    output logic leak_pending,
    output logic leak_overrun
);

    localparam int CW = $clog2(LEAK_PERIOD);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = leak_en && (cnt == CW'(LEAK_PERIOD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            leak_pending <= 1'b0;
            leak_overrun <= 1'b0;
        end else begin
            if (!leak_en || tick) cnt <= '0;
            else                  cnt <= cnt + 1'b1;
            // A new tick always leaves pending set, even if the old one is
            // being consumed this same cycle.
            leak_pending <= tick | (leak_pending & ~clear_i);
            // A tick landing on a pending flag that is being consumed is not
            // lost, so it is not counted as an overrun.
            if (tick && leak_pending && !clear_i) leak_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/snn_event_scheduler.sv
// Front-end event scheduler: arbitrates sensor, recurrent and leak events and
// issues one at a time to the core controller, waiting for ctrl_done between.
//   sensor_valid/addr/ren : sensor FIFO interface (ren = 1-cycle pop)
//   recur_valid/addr/ren  : recurrent spike FIFO interface
//   leak_en               : enables the periodic leak timer
//   event_received/addr/type : 1-cycle start strobe + latched event descriptor
//   ctrl_done             : controller finished the pass (honoured in WAIT only)
//   busy                  : scheduler not idle
//   leak_overrun, timeout_err : sticky error flags, cleared by reset only
module snn_event_scheduler
    import snn_pkg::*;
#(
    parameter  int NEURONS     = 16,
    parameter  int LEAK_PERIOD = 1024,
    parameter  int TIMEOUT     = 4096,
    localparam int NA          = $clog2(NEURONS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sensor_valid,
    input  logic [NA-1:0] sensor_addr,
    output logic          sensor_ren,
    input  logic          recur_valid,
    input  logic [NA-1:0] recur_addr,
    output logic          recur_ren,
    input  logic          leak_en,
    output logic          event_received,
    output logic [NA-1:0] event_addr,
    output event_type_t   event_type,
    input  logic          ctrl_done,
    output logic          busy,
    output logic          leak_overrun,
    output logic          timeout_err
);

    localparam int WW = $clog2(TIMEOUT);

    sched_state_t  state, state_d;
    event_type_t   rr_last;
    logic [WW-1:0] wait_cnt;
    logic          leak_pending, leak_clear;
    logic          grant_valid, issue_start, timeout_hit;
    event_type_t   grant_type;
    logic [NA-1:0] grant_addr;

    // The LEAK event is consumed on its ISSUE cycle.
    assign leak_clear = (state == ISSUE) && (event_type == LEAK);

    snn_leak_timer #(.LEAK_PERIOD(LEAK_PERIOD)) u_leak (
        .clock        (clock),
        .reset        (reset),
        .leak_en      (leak_en),
        .clear_i      (leak_clear),
        .leak_pending (leak_pending),
        .leak_overrun (leak_overrun)
    );

    always_comb begin
        state_d     = state;
        grant_valid = 1'b0;
        grant_type  = SENSOR;
        grant_addr  = '0;
        timeout_hit = 1'b0;

        // Leak first; sensor wins a contest unless it won the last one.
        if (leak_pending) begin
            grant_valid = 1'b1;
            grant_type  = LEAK;
        end else if (sensor_valid && (!recur_valid || rr_last == RECUR)) begin
            grant_valid = 1'b1;
            grant_type  = SENSOR;
            grant_addr  = sensor_addr;
        end else if (recur_valid) begin
            grant_valid = 1'b1;
            grant_type  = RECUR;
            grant_addr  = recur_addr;
        end

        case (state)
            IDLE:  if (grant_valid) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (ctrl_done) begin
                    state_d = IDLE;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_start = (state == IDLE) && (state_d == ISSUE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            rr_last        <= RECUR;
            wait_cnt       <= '0;
            event_received <= 1'b0;
            sensor_ren     <= 1'b0;
            recur_ren      <= 1'b0;
            event_addr     <= '0;
            event_type     <= SENSOR;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_d;
            busy           <= (state_d != IDLE);
            event_received <= issue_start;
            sensor_ren     <= issue_start && (grant_type == SENSOR);
            recur_ren      <= issue_start && (grant_type == RECUR);
            if (issue_start) begin
                event_addr <= grant_addr;
                event_type <= grant_type;
                if (grant_type != LEAK) rr_last <= grant_type;
            end
            // Zero everywhere outside WAIT, so it starts at 0 on WAIT entry.
            if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            else               wait_cnt <= '0;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

endmodule
